// File: rtl/microwave_pkg.sv
// Shared state encoding, level constants and power-key decode helpers
// for the microwave controller blocks.
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int LEVEL_W       = 4;
    localparam int DEFAULT_LEVEL = 10;
    localparam int DEFROST_LEVEL = 3;
    localparam int NUM_KEYS      = 10;

    // Counter width that stays legal for a modulus of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic keys_onehot(input logic [NUM_KEYS-1:0] keys);
        int ones;
        ones = 0;
        for (int k = 0; k < NUM_KEYS; k++) ones += int'(keys[k]);
        return ones == 1;
    endfunction

    // Key k selects level k; key 0 is the "10" key.
    function automatic logic [LEVEL_W-1:0] keys_to_level(input logic [NUM_KEYS-1:0] keys);
        logic [LEVEL_W-1:0] lv;
        lv = LEVEL_W'(DEFAULT_LEVEL);
        for (int k = 1; k < NUM_KEYS; k++) begin
            if (keys[k]) lv = LEVEL_W'(k);
        end
        return lv;
    endfunction

endpackage

// File: rtl/mag_power_sched_if.sv
// Control/status signals of the magnetron power scheduler. The defrost
// request exists only when MAG_DEFROST_EN is defined.
interface mag_power_sched_if;
    import microwave_pkg::*;

    logic                cook_req;
    logic                door_closed;
    logic [NUM_KEYS-1:0] power_keys;
    logic                power_set;
`ifdef MAG_DEFROST_EN
    logic                defrost;
`endif
    logic                mag_on;
    logic [LEVEL_W-1:0]  level;
    logic                key_err;

    modport master (
`ifdef MAG_DEFROST_EN
        output defrost,
`endif
        output cook_req, door_closed, power_keys, power_set,
        input  mag_on, level, key_err
    );

    modport slave (
`ifdef MAG_DEFROST_EN
        input  defrost,
`endif
        input  cook_req, door_closed, power_keys, power_set,
        output mag_on, level, key_err
    );

endinterface

// File: rtl/mag_slot_timer.sv
// Prescaler plus one-second slot counter for the power-modulation window.
// clear zeroes both counters, freeze holds them.
module mag_slot_timer
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int WINDOW_SEC    = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         freeze,
    output logic [cnt_w(WINDOW_SEC)-1:0] slot,
    output logic                         tick
);

    localparam int PRESC_W = cnt_w(TICKS_PER_SEC);
    localparam int SLOT_W  = cnt_w(WINDOW_SEC);

    logic [PRESC_W-1:0] presc;
    logic               wrap;

    assign wrap = (presc == PRESC_W'(TICKS_PER_SEC - 1));
    assign tick = wrap & ~freeze & ~clear;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            presc <= '0;
            slot  <= '0;
        end else if (!freeze) begin
            if (wrap) begin
                presc <= '0;
                slot  <= (slot == SLOT_W'(WINDOW_SEC - 1)) ? '0 : slot + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mag_power_sched.sv
// Magnetron power scheduler: on/off duty per window from the selected level.
// MAG_DEFROST_EN adds a defrost input that forces an effective level of 3 in RUN.
module mag_power_sched
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int WINDOW_SEC    = 10
) (
    input  logic               clock,
    input  logic               reset,
    mag_power_sched_if.slave   bus
);

    localparam int SLOT_W = cnt_w(WINDOW_SEC);

    state_t             state, state_nxt;
    logic [LEVEL_W-1:0] level_q, eff_level;
    logic               key_err_q;
    logic               tmr_clear, tmr_freeze;
    logic               mag_on;
    logic               unused_tick;
    logic [SLOT_W-1:0]  slot;

    assign bus.mag_on  = mag_on;
    assign bus.level   = level_q;
    assign bus.key_err = key_err_q;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // The window only advances while the magnetron could actually be heating,
    // so an open door in RUN does not silently consume on-time.
    always_comb begin
        state_nxt  = state;
        tmr_clear  = 1'b0;
        tmr_freeze = 1'b1;
        case (state)
            IDLE: begin
                tmr_clear = 1'b1;
                if (bus.cook_req && bus.door_closed) state_nxt = RUN;
            end
            RUN: begin
                tmr_freeze = ~bus.door_closed;
                if (!bus.cook_req)         state_nxt = IDLE;
                else if (!bus.door_closed) state_nxt = PAUSE;
            end
            PAUSE: begin
                if (!bus.cook_req)        state_nxt = IDLE;
                else if (bus.door_closed) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        eff_level = level_q;
`ifdef MAG_DEFROST_EN
        if (bus.defrost && state == RUN) eff_level = LEVEL_W'(DEFROST_LEVEL);
`endif
        mag_on = (state == RUN) && bus.door_closed && (32'(slot) < 32'(eff_level));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q   <= LEVEL_W'(DEFAULT_LEVEL);
            key_err_q <= 1'b0;
        end else begin
            key_err_q <= 1'b0;
            if (bus.power_set && state == IDLE) begin
                if (keys_onehot(bus.power_keys)) level_q   <= keys_to_level(bus.power_keys);
                else                             key_err_q <= 1'b1;
            end
        end
    end

    mag_slot_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .WINDOW_SEC    (WINDOW_SEC)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmr_clear),
        .freeze (tmr_freeze),
        .slot   (slot),
        .tick   (unused_tick)
    );

endmodule
